// File: rtl/pipe_pkg.sv
// Shared defaults and control-bundle layout for the inter-stage pipeline registers.
// Bundles are carried as flat vectors; the typedefs document the per-stage packing.
package pipe_pkg;

    localparam int CTRL_W_DEF = 10;
    localparam int DATA_W_DEF = 128;
    localparam int CNT_W_DEF  = 16;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_BRANCH   = 3;
    localparam int CTRL_JUMP     = 4;
    localparam int CTRL_ALUSRC   = 5;
    localparam int CTRL_ALUOP    = 6;
    localparam int CTRL_ALUOP_W  = 4;

    typedef struct packed {
        logic [3:0] aluop;
        logic       alusrc;
        logic       jump;
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [63:0] rsvd;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [19:0] imm;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [3:0]  rsvd;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_res;
        logic [31:0] st_data;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [23:0] rsvd;
    } ex_mem_t;

endpackage

// File: rtl/pipe_slot.sv
// One valid+ctrl+data register; clear makes a bubble (ctrl zeroed, data held).
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load) begin
            valid_d = 1'b1;
            ctrl_d  = ld_ctrl;
            data_d  = ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign ctrl  = ctrl_q;
    assign data  = data_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline register with flush bubbles and saturating stall counter.
// Define PIPE_SKID_BUFFER_EN for a 2-entry slot with a registered in_ready.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              in_fire, out_fire;
    logic              main_load, main_clr;
    logic [CTRL_W-1:0] main_ctrl_src;
    logic [DATA_W-1:0] main_data_src;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .reset   (reset),
        .load    (main_load),
        .clear   (main_clr),
        .ld_ctrl (main_ctrl_src),
        .ld_data (main_data_src),
        .valid   (out_valid),
        .ctrl    (out_ctrl),
        .data    (out_data)
    );

`ifdef PIPE_SKID_BUFFER_EN
    logic              skid_valid, skid_load, skid_clr;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (skid_load),
        .clear   (skid_clr),
        .ld_ctrl (in_ctrl),
        .ld_data (in_data),
        .valid   (skid_valid),
        .ctrl    (skid_ctrl),
        .data    (skid_data)
    );

    // ready comes straight from the skid flop; flush only widens it
    assign in_ready = ~skid_valid | flush;

    always_comb begin
        main_load     = 1'b0;
        main_clr      = 1'b0;
        skid_load     = 1'b0;
        skid_clr      = 1'b0;
        main_ctrl_src = in_ctrl;
        main_data_src = in_data;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (out_fire) begin
            if (skid_valid) begin
                main_load     = 1'b1;
                main_ctrl_src = skid_ctrl;
                main_data_src = skid_data;
                skid_clr      = 1'b1;
            end else if (in_fire) begin
                main_load = 1'b1;
            end else begin
                main_clr = 1'b1;
            end
        end else if (in_fire) begin
            if (out_valid) begin
                skid_load = 1'b1;
            end else begin
                main_load = 1'b1;
            end
        end
    end
`else
    assign in_ready      = ~out_valid | out_ready | flush;
    assign main_ctrl_src = in_ctrl;
    assign main_data_src = in_data;

    always_comb begin
        main_load = 1'b0;
        main_clr  = 1'b0;
        if (flush) begin
            main_clr = 1'b1;
        end else if (in_fire) begin
            main_load = 1'b1;
        end else if (out_fire) begin
            main_clr = 1'b1;
        end
    end
`endif

    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && !(&stall_q)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Self-checking bench for pipe_stage_hs: vector table, corner sequences, random scoreboard.
// Expectations follow the build: PIPE_SKID_BUFFER_EN selects the 2-entry behaviour.
module tb_pipe_stage_hs;

`ifdef PIPE_SKID_BUFFER_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam int DEPTH = SKID ? 2 : 1;

    logic         clk;
    logic         reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [9:0]   in_ctrl, out_ctrl;
    logic [127:0] in_data, out_data;
    logic [15:0]  stall_cnt;

    logic         s_reset, s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [9:0]   s_in_ctrl, s_out_ctrl;
    logic [127:0] s_in_data, s_out_data;
    logic [3:0]   s_stall_cnt;

    int errors = 0;
    int checks = 0;

    pipe_stage_hs u_dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    pipe_stage_hs #(.CNT_W(4)) u_sat (
        .clk       (clk),
        .reset     (s_reset),
        .flush     (s_flush),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_ctrl   (s_in_ctrl),
        .in_data   (s_in_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_ctrl  (s_out_ctrl),
        .out_data  (s_out_data),
        .stall_cnt (s_stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         iv;
        logic [9:0]   ic;
        logic [127:0] id;
        logic         ordy;
        logic         ev;
        logic [9:0]   ec;
        logic [127:0] ed;
    } vec_t;

    typedef struct {
        logic [9:0]   c;
        logic [127:0] d;
    } beat_t;

    vec_t  tbl[9];
    beat_t q[$];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int       mdl_stall;
        logic     exp_rdy, ofire, ifire;
        logic     ov, orr, fl;

        reset       = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b1;
        in_ctrl     = 10'h3FF;
        in_data     = '1;
        out_ready   = 1'b0;
        s_reset     = 1'b1;
        s_flush     = 1'b0;
        s_in_valid  = 1'b0;
        s_in_ctrl   = '0;
        s_in_data   = '0;
        s_out_ready = 1'b0;

        // reset held two cycles with a beat pending
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst_valid", 128'(out_valid), 128'(0));
            chk("rst_ctrl", 128'(out_ctrl), 128'(0));
            chk("rst_data", out_data, 128'(0));
            chk("rst_stall", 128'(stall_cnt), 128'(0));
        end
        reset    = 1'b0;
        s_reset  = 1'b0;
        in_valid = 1'b0;

        // streaming vectors: one beat per cycle, then an idle bubble
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{1'b1, 10'(i * 37 + 1), 128'(i + 1), 1'b1,
                       1'b1, 10'(i * 37 + 1), 128'(i + 1)};
        end
        tbl[8] = '{1'b0, 10'h3FF, 128'hBAD, 1'b1, 1'b0, 10'h0, 128'(8)};

        for (int i = 0; i < 9; i++) begin
            in_valid  = tbl[i].iv;
            in_ctrl   = tbl[i].ic;
            in_data   = tbl[i].id;
            out_ready = tbl[i].ordy;
            #1;
            chk("tbl_in_ready", 128'(in_ready), 128'(1));
            tick();
            chk("tbl_valid", 128'(out_valid), 128'(tbl[i].ev));
            chk("tbl_ctrl", 128'(out_ctrl), 128'(tbl[i].ec));
            chk("tbl_data", out_data, tbl[i].ed);
        end
        chk("tbl_stall", 128'(stall_cnt), 128'(0));

        // beat A stalled 5 cycles while B waits upstream
        in_valid  = 1'b1;
        in_ctrl   = 10'h155;
        in_data   = 128'hA;
        out_ready = 1'b1;
        tick();
        chk("a_valid", 128'(out_valid), 128'(1));
        chk("a_ctrl", 128'(out_ctrl), 128'h155);
        in_ctrl   = 10'h0F3;
        in_data   = 128'hB;
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            #1;
            chk("stall_in_ready", 128'(in_ready), 128'(SKID && k == 1));
            tick();
            if (SKID) in_valid = 1'b0;
            chk("stall_valid", 128'(out_valid), 128'(1));
            chk("stall_ctrl", 128'(out_ctrl), 128'h155);
            chk("stall_data", out_data, 128'hA);
            chk("stall_cnt", 128'(stall_cnt), 128'(k));
        end
        out_ready = 1'b1;
        in_valid  = !SKID;
        #1;
        chk("release_in_ready", 128'(in_ready), 128'(!SKID));
        tick();
        in_valid = 1'b0;
        chk("b_valid", 128'(out_valid), 128'(1));
        chk("b_ctrl", 128'(out_ctrl), 128'h0F3);
        chk("b_data", out_data, 128'hB);
        chk("b_in_ready", 128'(in_ready), 128'(1));
        tick();
        chk("drain_valid", 128'(out_valid), 128'(0));
        chk("drain_ctrl", 128'(out_ctrl), 128'(0));
        chk("drain_data", out_data, 128'hB);
        chk("drain_stall", 128'(stall_cnt), 128'(5));

        // flush with a held beat and an incoming beat
        in_valid = 1'b1;
        in_ctrl  = 10'h0C1;
        in_data  = 128'hC;
        tick();
        chk("c_valid", 128'(out_valid), 128'(1));
        in_ctrl = 10'h2AA;
        in_data = 128'hDEAD;
        flush   = 1'b1;
        #1;
        chk("flush_in_ready", 128'(in_ready), 128'(1));
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 128'(out_valid), 128'(0));
        chk("flush_ctrl", 128'(out_ctrl), 128'(0));
        chk("flush_data", out_data, 128'hC);
        chk("flush_stall", 128'(stall_cnt), 128'(5));
        tick();
        chk("flush_nobeat", 128'(out_valid), 128'(0));

        // 4-bit counter saturation, then reset clears it
        s_in_valid = 1'b1;
        s_in_ctrl  = 10'h1;
        s_in_data  = 128'h1;
        tick();
        s_in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("sat_cnt", 128'(s_stall_cnt), 128'((k > 15) ? 15 : k));
        end
        chk("sat_hold_data", s_out_data, 128'h1);
        s_reset = 1'b1;
        tick();
        s_reset = 1'b0;
        chk("sat_reset", 128'(s_stall_cnt), 128'(0));
        chk("sat_reset_valid", 128'(s_out_valid), 128'(0));

        // random traffic against a queue model of the stage
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q.delete();
        mdl_stall = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            ov  = ($urandom_range(3) != 0);
            orr = ($urandom_range(2) != 0);
            fl  = ($urandom_range(31) == 0);
            in_valid  = ov;
            out_ready = orr;
            flush     = fl;
            in_ctrl   = 10'($urandom);
            in_data   = {32'(cyc), $urandom, $urandom, $urandom};
            #1;
            exp_rdy = SKID ? (q.size() < DEPTH || fl)
                           : (q.size() == 0 || orr || fl);
            chk("rnd_in_ready", 128'(in_ready), 128'(exp_rdy));
            chk("rnd_valid", 128'(out_valid), 128'(q.size() > 0));
            chk("rnd_ctrl", 128'(out_ctrl),
                128'((q.size() > 0) ? q[0].c : 10'h0));
            if (q.size() > 0) chk("rnd_data", out_data, q[0].d);
            chk("rnd_stall", 128'(stall_cnt), 128'(mdl_stall));

            ifire = ov && exp_rdy;
            ofire = (q.size() > 0) && orr;
            if (q.size() > 0 && !orr && mdl_stall < 65535) mdl_stall++;
            if (fl) begin
                q.delete();
            end else begin
                if (ofire) void'(q.pop_front());
                if (ifire) q.push_back('{in_ctrl, in_data});
            end
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
